// File: rtl/msc_pkg.sv
// msc_pkg: shared types and defaults for the footswitch conditioning blocks
package msc_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } debounce_state_t;

    localparam int DEBOUNCE_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce.sv
// debounce: accepts a new footswitch level after STABLE_CYCLES identical samples and derives edge pulses and a toggle
module debounce
    import msc_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES,
    parameter bit INIT_VALUE    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int            CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam debounce_state_t INIT_STATE = INIT_VALUE ? STABLE_HI : STABLE_LO;

    debounce_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            toggle_q, toggle_d;

    // next state: a run of the opposite level counts up, any sample matching the current level abandons it
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;
        case (state_q)
            STABLE_LO: begin
                if (sig_i) begin
                    state_d = WAIT_HI;
                    cnt_d   = ONE;
                end
            end
            WAIT_HI: begin
                if (!sig_i) begin
                    state_d = STABLE_LO;
                end else if (cnt_q == LAST) begin
                    state_d  = STABLE_HI;
                    rise_d   = 1'b1;
                    toggle_d = ~toggle_q;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            STABLE_HI: begin
                if (!sig_i) begin
                    state_d = WAIT_LO;
                    cnt_d   = ONE;
                end
            end
            WAIT_LO: begin
                if (sig_i) begin
                    state_d = STABLE_HI;
                end else if (cnt_q == LAST) begin
                    state_d = STABLE_LO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = INIT_STATE;
        endcase
    end

    // state register; reset wins over any acceptance on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= INIT_STATE;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= INIT_VALUE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign level_o  = (state_q == STABLE_HI) || (state_q == WAIT_LO);
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = toggle_q;

endmodule

// File: tb/tb_debounce.sv
// tb_debounce: scoreboard bench for debounce with INIT_VALUE 0 and 1 instances side by side
module tb_debounce;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sig_i = 1'b0;
    logic [1:0] lvl, rise, fall, tog;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       m_lvl[2];
    logic       m_tog[2];
    int         m_run[2];

    always #5 clk = ~clk;

    debounce #(.STABLE_CYCLES(SC), .INIT_VALUE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sig_i(sig_i),
        .level_o(lvl[0]), .rise_o(rise[0]), .fall_o(fall[0]), .toggle_o(tog[0])
    );

    debounce #(.STABLE_CYCLES(SC), .INIT_VALUE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sig_i(sig_i),
        .level_o(lvl[1]), .rise_o(rise[1]), .fall_o(fall[1]), .toggle_o(tog[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // model: count consecutive samples that differ from the accepted level; accept on the SC-th
    task automatic cyc(input logic r, input logic s);
        logic [7:0] e;
        logic [7:0] got;
        logic [7:0] want;
        rst   = r;
        sig_i = s;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            logic rp, fp;
            rp = 1'b0;
            fp = 1'b0;
            if (!r) begin
                m_lvl[i] = (i == 1);
                m_tog[i] = (i == 1);
                m_run[i] = 0;
            end else if (s != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == SC) begin
                    m_lvl[i] = s;
                    m_run[i] = 0;
                    rp = s;
                    fp = !s;
                    if (s) m_tog[i] = !m_tog[i];
                end
            end else begin
                m_run[i] = 0;
            end
            e[i*4 +: 4] = {m_lvl[i], rp, fp, m_tog[i]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = {lvl[1], rise[1], fall[1], tog[1], lvl[0], rise[0], fall[0], tog[0]};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("level%0d", i),  got[i*4+3], want[i*4+3]);
            chk($sformatf("rise%0d", i),   got[i*4+2], want[i*4+2]);
            chk($sformatf("fall%0d", i),   got[i*4+1], want[i*4+1]);
            chk($sformatf("toggle%0d", i), got[i*4+0], want[i*4+0]);
            chk($sformatf("excl%0d", i),   int'(got[i*4+2] & got[i*4+1]), 0);
        end
    endtask

    task automatic hold(input logic r, input logic s, input int n);
        for (int k = 0; k < n; k++) cyc(r, s);
    endtask

    initial begin
        int edge_at;
        m_lvl[0] = 1'b0; m_lvl[1] = 1'b1;
        m_tog[0] = 1'b0; m_tog[1] = 1'b1;
        m_run[0] = 0;    m_run[1] = 0;
        // reset with sig low, then release
        hold(1'b0, 1'b0, 2);
        chk("rst_level0", lvl[0], 0);
        chk("rst_level1", lvl[1], 1);
        chk("rst_toggle1", tog[1], 1);
        hold(1'b1, 1'b0, 6);
        // press held: rise exactly on the 4th sampling edge
        edge_at = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b1);
            if (rise[0] && edge_at == 0) edge_at = k;
        end
        chk("rise_edge", edge_at, SC);
        chk("press_toggle", tog[0], 1);
        // short glitch low from high, then release held low
        hold(1'b1, 1'b0, 3);
        hold(1'b1, 1'b1, 2);
        chk("glitch_hi_level", lvl[0], 1);
        edge_at = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b0);
            if (fall[0] && edge_at == 0) edge_at = k;
        end
        chk("fall_edge", edge_at, SC);
        chk("fall_keeps_toggle", tog[0], 1);
        // glitch of SC-1 high samples
        hold(1'b1, 1'b1, SC - 1);
        hold(1'b1, 1'b0, 3);
        chk("glitch_lo_level", lvl[0], 0);
        // second press toggles back
        hold(1'b1, 1'b1, 5);
        hold(1'b1, 1'b0, 5);
        chk("second_press_toggle", tog[0], 0);
        // reset mid-wait discards the partial count
        hold(1'b1, 1'b1, 2);
        cyc(1'b0, 1'b1);
        edge_at = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b1, 1'b1);
            if (rise[0] && edge_at == 0) edge_at = k;
        end
        chk("rst_mid_wait_rise", edge_at, SC);
        // random runs with occasional reset
        for (int n = 0; n < 60; n++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            hold(($urandom_range(0, 19) != 0), s, $urandom_range(1, 6));
        end
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
